// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the CPU decoder.
// Holds opcode codes, instruction-word field positions, the STP word,
// the immediate-form classifier and the encoder state type.
package isa_pkg;

  // Opcode codes (5-bit, word[15:11])
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_CALL  = 5'b00001;
  localparam logic [4:0] OP_JMP_I = 5'b00101;
  localparam logic [4:0] OP_ADD_R = 5'b01000;
  localparam logic [4:0] OP_ADD_I = 5'b01001;
  localparam logic [4:0] OP_SUB_I = 5'b01011;
  localparam logic [4:0] OP_MAS_I = 5'b01101;
  localparam logic [4:0] OP_MOV_I = 5'b01111;
  localparam logic [4:0] OP_SET_I = 5'b10111;
  localparam logic [4:0] OP_STP   = 5'b11111;

  // Field positions inside a 16-bit instruction word
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 11;
  localparam int RD_MSB   = 10;
  localparam int RD_LSB   = 8;
  localparam int RS_MSB   = 7;
  localparam int RS_LSB   = 5;
  localparam int COND_MSB = 4;
  localparam int COND_LSB = 0;

  // STP with every operand field zero
  localparam logic [15:0] STP_WORD = 16'hF800;

  typedef enum logic [1:0] {
    EMIT = 2'd0,
    IMM  = 2'd1,
    STOP = 2'd2,
    HALT = 2'd3
  } state_t;

  // Immediate-form ops are followed in memory by a word carrying N.
  function automatic logic needs_imm(input logic [4:0] opcode);
    logic r;
    case (opcode)
      OP_CALL, OP_JMP_I, OP_ADD_I, OP_SUB_I,
      OP_MAS_I, OP_MOV_I, OP_SET_I: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Program-loader write side of the instruction RAM (port 2).
// Accepts one structured instruction per valid/ready handshake, packs it into
// a 16-bit ISA word and writes it at the next address. Immediate-form ops
// are followed by a word holding N; the last instruction is followed by STP.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, start_addr          (re)start a program load at start_addr
//   in_valid / in_ready        instruction handshake (in_ready combinational)
//   in_opcode/rd/rs/cond/imm   instruction fields, sampled on accept
//   in_last                    final instruction; STP is appended after it
//   instr_wen/waddr/wdata      registered RAM write port
//   words_written              words written since start/reset (saturating)
//   done                       1-cycle pulse together with the STP write
//   overflow                   sticky: write attempted at ptr >= DEPTH
//
// state | meaning
// EMIT  | ready for an instruction; op word written the cycle after accept
// IMM   | writing the captured immediate word
// STOP  | writing STP and pulsing done
// HALT  | program finished or overflowed; idle until start
module instr_encoder
  import isa_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs,
  input  logic [4:0]        in_cond,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              instr_wen,
  output logic [ADDR_W-1:0] instr_waddr,
  output logic [15:0]       instr_wdata,
  output logic [15:0]       words_written,
  output logic              done,
  output logic              overflow
);

  // One extra bit so DEPTH = 2**ADDR_W is representable; a full-range
  // pointer then never reports out-of-bounds and simply wraps.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       imm_q;
  logic              last_q;

  logic        ptr_oob;
  logic [15:0] op_word;
  logic        wr_req;
  logic [15:0] wr_data;

  assign ptr_oob  = ({1'b0, ptr} >= DEPTH_LIM);
  assign op_word  = {in_opcode, in_rd, in_rs, in_cond};
  assign in_ready = (state == EMIT) && !overflow && !start;

  // Which word (if any) the current state wants to write at the next edge.
  always_comb begin
    wr_req  = 1'b0;
    wr_data = op_word;
    case (state)
      EMIT: begin
        wr_req  = in_valid && in_ready;
        wr_data = op_word;
      end
      IMM: begin
        wr_req  = 1'b1;
        wr_data = imm_q;
      end
      STOP: begin
        wr_req  = 1'b1;
        wr_data = STP_WORD;
      end
      default: begin
        wr_req  = 1'b0;
        wr_data = op_word;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EMIT;
      ptr           <= '0;
      imm_q         <= '0;
      last_q        <= 1'b0;
      instr_wen     <= 1'b0;
      instr_waddr   <= '0;
      instr_wdata   <= '0;
      words_written <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      instr_wen <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        // Restart wins over everything, including a pending IMM/STOP write.
        ptr           <= start_addr;
        words_written <= '0;
        overflow      <= 1'b0;
        state         <= EMIT;
      end else if (wr_req) begin
        if (ptr_oob) begin
          overflow <= 1'b1;
          state    <= HALT;
        end else begin
          instr_wen   <= 1'b1;
          instr_waddr <= ptr;
          instr_wdata <= wr_data;
          ptr         <= ptr + ADDR_W'(1);
          if (words_written != 16'hFFFF) begin
            words_written <= words_written + 16'd1;
          end
          case (state)
            EMIT: begin
              if (needs_imm(in_opcode)) begin
                imm_q  <= in_imm;
                last_q <= in_last;
                state  <= IMM;
              end else if (in_last) begin
                state <= STOP;
              end
            end
            IMM: begin
              state <= last_q ? STOP : EMIT;
            end
            STOP: begin
              done  <= 1'b1;
              state <= HALT;
            end
            default: state <= HALT;
          endcase
        end
      end
    end
  end

endmodule
